dmem_gen: RTL and testbench
===========================

DMEM_GEN -- requirements
Module: dmem_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits; a multiple of 8, at least 8.
REQ-002 SHALL have parameter DEPTH, default 32: number of words; even, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 8: address port width; 2^ADDR_W >= DEPTH.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port clear, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port ctrl_memread, input, 1: read request.
REQ-007 SHALL have port ctrl_memwrite, input, 1: write request.
REQ-008 SHALL have port ctrl_byteen, input, DATA_W/8: per-byte write enables; bit k covers data bits 8k+7:8k.
REQ-009 SHALL have port addr, input, ADDR_W: word address.
REQ-010 SHALL have port data_in, input, DATA_W: write data.
REQ-011 SHALL have port data_out, output, DATA_W: registered read data.
REQ-012 SHALL have port rd_valid, output, 1: one-cycle pulse; data_out is valid this cycle.
REQ-013 SHALL have port busy, output, 1: initialisation in progress; requests are ignored.
REQ-014 SHALL have port addr_err, output, 1: one-cycle pulse flagging an out-of-range accepted request.

Function
REQ-015 SHALL implement states INIT and IDLE. Clear forces INIT with init pointer 0. INIT goes to IDLE after the pointer = DEPTH-1 write.
REQ-016 SHALL, in INIT with clear low, write init_val(ptr) to word ptr and increment ptr, one word per cycle, DEPTH cycles total.
REQ-017 SHALL define init_val(i) as follows, with H = DEPTH/2, truncated to DATA_W:
- i for i < H
- 0 for i = H
- two's complement -(i-H) for i > H
REQ-018 SHALL hold busy=1 in INIT and busy=0 in IDLE; busy falls the cycle after the last init write.
REQ-019 SHALL accept requests only in IDLE; requests while busy=1 are dropped with no response and no memory change.
REQ-020 SHALL, on an accepted write with addr < DEPTH, update only the bytes whose ctrl_byteen bit is 1.
REQ-021 SHALL, on an accepted read, register mem[addr] into data_out and pulse rd_valid exactly one cycle later (latency 1).
REQ-022 SHALL hold data_out between reads.
REQ-023 SHALL, on a read and a write to the same address in the same cycle, return the old word (read-first); the write still takes effect.
REQ-024 SHALL, for an accepted request with addr >= DEPTH:
- ignore the write
- return data_out=0 with rd_valid for a read
- pulse addr_err one cycle later
REQ-025 SHALL allow back-to-back reads every cycle, each producing its own rd_valid pulse.

Reset
REQ-026 SHALL, while clear=1: set data_out=0, rd_valid=0, addr_err=0, busy=1, state=INIT, ptr=0; no memory writes.
REQ-027 SHALL, if clear is asserted mid-INIT or mid-operation, abandon the current sequence and restart initialisation from word 0 after clear falls.
REQ-028 SHALL make memory contents valid only after busy falls; no other reset of the array is required.

Structure
REQ-029 SHALL place the init_val function and the state encoding constants in the shared package dmem_pkg.
REQ-030 SHALL implement INIT/IDLE, ptr and busy as one sub-module dmem_init_seq, which supplies write address, data and enable to the array.

Verification
REQ-031 SHALL verify init: defaults, clear high 2 cycles then low -> busy high for 32 cycles; afterwards reads of addr 5, 16, 17, 31 return 0x05, 0x00, 0xFF, 0xF1, each with rd_valid one cycle after the request.
REQ-032 SHALL verify the busy drop: write 0xAA to addr 3 while busy=1 -> after init, read addr 3 returns 0x03.
REQ-033 SHALL verify byte enables: DATA_W=16, DEPTH=8; write 0xBEEF with ctrl_byteen=2'b10 to addr 2 (init 0x0002) -> read returns 0xBE02.
REQ-034 SHALL verify read-first: same cycle, write 0x5A and read addr 7 -> data_out=0x07; the next read of addr 7 returns 0x5A.
REQ-035 SHALL verify out-of-range: read addr 40 -> data_out=0x00, rd_valid=1 and addr_err=1 one cycle later; write addr 40 leaves all 32 words unchanged.
REQ-036 SHALL verify reset mid-init: clear pulsed at init cycle 10 -> busy stays high for a further 32 cycles; all words match init_val.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the self-initialising data memory.
// State encoding and the power-on pattern generator live here.
package dmem_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  // Ramp up to H-1, zero at H, then descending negatives.
  function automatic logic [63:0] init_val(
    input int i,
    input int depth
  );
    int h;
    h = depth / 2;
    if (i < h)
      return 64'(i);
    else if (i == h)
      return '0;
    else
      return -(64'(i - h));
  endfunction

endpackage

// File: rtl/dmem_init_seq.sv
// Init sequencer: walks every word once after clear, then parks in IDLE.
// Drives the array write port while busy.
module dmem_init_seq
  import dmem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clock,
  input  logic              clear,
  output logic              busy,
  output logic              we,
  output logic [IDX_W-1:0]  waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      if (ptr == LAST) begin
        state <= ST_IDLE;
        ptr   <= '0;
      end else begin
        ptr <= ptr + IDX_W'(1);
      end
    end
  end

  assign busy  = (state == ST_INIT);
  assign we    = busy && !clear;
  assign waddr = ptr;
  assign wdata = DATA_W'(init_val(int'(ptr), DEPTH));

endmodule

// File: rtl/dmem_gen.sv
// Byte-writable data memory with registered read-first port
// and a built-in power-on initialisation pattern.
module dmem_gen
  import dmem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  ctrl_memread,
  input  logic                  ctrl_memwrite,
  input  logic [DATA_W/8-1:0]   ctrl_byteen,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [IDX_W-1:0]  init_addr;
  logic [DATA_W-1:0] init_data;

  logic             in_range;
  logic             accept;
  logic             wr_ok;
  logic [IDX_W-1:0] idx;

  dmem_init_seq #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_seq (
    .clock (clock),
    .clear (clear),
    .busy  (busy),
    .we    (init_we),
    .waddr (init_addr),
    .wdata (init_data)
  );

  assign in_range = (32'(addr) < 32'(DEPTH));
  assign idx      = addr[IDX_W-1:0];
  assign accept   = !busy && !clear;
  assign wr_ok    = accept && ctrl_memwrite && in_range;

  always_ff @(posedge clock) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (wr_ok) begin
      for (int k = 0; k < NB; k++)
        if (ctrl_byteen[k])
          mem[idx][8*k +: 8] <= data_in[8*k +: 8];
    end
  end

  // Read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clock) begin
    if (clear) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= accept && ctrl_memread;
      addr_err <= accept && (ctrl_memread || ctrl_memwrite)
                  && !in_range;
      if (accept && ctrl_memread)
        data_out <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_dmem_gen.sv
// Directed bench: 8-bit x 32 instance for the main checks,
// 16-bit x 8 instance for byte-enable behaviour.
module tb_dmem_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 1'b1;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [0:0] be = 1'b1;
  logic [7:0] a  = '0;
  logic [7:0] d  = '0;
  logic [7:0] dout;
  logic       v, b, e;

  logic        rd2 = 1'b0;
  logic        wr2 = 1'b0;
  logic [1:0]  be2 = 2'b11;
  logic [7:0]  a2  = '0;
  logic [15:0] d2  = '0;
  logic [15:0] dout2;
  logic        v2, b2, e2;

  dmem_gen u_dut (
    .clock         (clk),
    .clear         (clear),
    .ctrl_memread  (rd),
    .ctrl_memwrite (wr),
    .ctrl_byteen   (be),
    .addr          (a),
    .data_in       (d),
    .data_out      (dout),
    .rd_valid      (v),
    .busy          (b),
    .addr_err      (e)
  );

  dmem_gen #(.DATA_W(16), .DEPTH(8), .ADDR_W(8)) u_dut2 (
    .clock         (clk),
    .clear         (clear),
    .ctrl_memread  (rd2),
    .ctrl_memwrite (wr2),
    .ctrl_byteen   (be2),
    .addr          (a2),
    .data_in       (d2),
    .data_out      (dout2),
    .rd_valid      (v2),
    .busy          (b2),
    .addr_err      (e2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
  } vec_t;

  vec_t       vt [12];
  logic [7:0] expm [32];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] iv(input int i);
    if (i < 16) return 8'(i);
    if (i == 16) return 8'h00;
    return 8'(256 - (i - 16));
  endfunction

  task automatic count_busy(input string name);
    int cnt = 0;
    while (b && cnt < 100) begin
      cnt++;
      tick();
    end
    chk(name, 64'(cnt), 64'd32);
  endtask

  task automatic scan(input string name);
    for (int i = 0; i < 32; i++) begin
      rd = 1'b1; wr = 1'b0; a = 8'(i);
      tick();
      rd = 1'b0;
      chk({name, "_v"}, 64'(v), 64'd1);
      chk({name, "_d"}, 64'(dout), 64'(expm[i]));
    end
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 8'd5,  8'h00, 1'b1, 8'h05, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 8'd16, 8'h00, 1'b1, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 8'd17, 8'h00, 1'b1, 8'hFF, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 8'd31, 8'h00, 1'b1, 8'hF1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 8'hF1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 8'd3,  8'h00, 1'b1, 8'h03, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 8'd7,  8'h5A, 1'b1, 8'h07, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 8'd7,  8'h00, 1'b1, 8'h5A, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 8'd40, 8'h00, 1'b1, 8'h00, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 8'd40, 8'hAA, 1'b0, 8'h00, 1'b1};
    vt[10] = '{1'b0, 1'b1, 8'd0,  8'h33, 1'b0, 8'h00, 1'b0};
    vt[11] = '{1'b1, 1'b0, 8'd0,  8'h00, 1'b1, 8'h33, 1'b0};

    tick();
    tick();
    chk("rst_busy",  64'(b), 64'd1);
    chk("rst_valid", 64'(v), 64'd0);
    chk("rst_dout",  64'(dout), 64'd0);
    chk("rst_err",   64'(e), 64'd0);

    clear = 1'b0;
    wr = 1'b1; rd = 1'b1; a = 8'd3; d = 8'hAA;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk("busy_drop_valid", 64'(v), 64'd0);
    chk("busy_drop_err",   64'(e), 64'd0);
    begin
      int cnt = 1;
      while (b && cnt < 100) begin
        cnt++;
        tick();
      end
      chk("init_busy_len", 64'(cnt), 64'd32);
    end

    for (int i = 0; i < 12; i++) begin
      rd = vt[i].rd; wr = vt[i].wr;
      a  = vt[i].addr; d = vt[i].din;
      tick();
      rd = 1'b0; wr = 1'b0;
      chk($sformatf("vec%0d_v", i), 64'(v), 64'(vt[i].ev));
      chk($sformatf("vec%0d_d", i), 64'(dout), 64'(vt[i].ed));
      chk($sformatf("vec%0d_e", i), 64'(e), 64'(vt[i].ee));
    end

    for (int i = 0; i < 32; i++) expm[i] = iv(i);
    expm[7] = 8'h5A;
    expm[0] = 8'h33;
    scan("oor_scan");

    chk("w16_busy", 64'(b2), 64'd0);
    rd2 = 1'b1; a2 = 8'd5;
    tick();
    rd2 = 1'b0;
    chk("w16_init5", 64'(dout2), 64'hFFFF);
    wr2 = 1'b1; a2 = 8'd2; d2 = 16'hBEEF; be2 = 2'b10;
    tick();
    wr2 = 1'b0; rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    chk("w16_be_v", 64'(v2), 64'd1);
    chk("w16_be_d", 64'(dout2), 64'hBE02);
    rd2 = 1'b1; a2 = 8'd9;
    tick();
    rd2 = 1'b0;
    chk("w16_oor_err", 64'(e2), 64'd1);
    chk("w16_oor_d",   64'(dout2), 64'd0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", 64'(b), 64'd1);
    clear = 1'b1;
    tick();
    chk("mid_clr_dout", 64'(dout), 64'd0);
    clear = 1'b0;
    count_busy("mid_busy_len");
    for (int i = 0; i < 32; i++) expm[i] = iv(i);
    scan("mid_scan");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
